// File: rtl/booking_pkg.sv
// Shared definitions for the booking datapath and its fault-recovery path.
// Provides the booking field widths, the fault limits used by fault detection,
// the recovery FSM state encoding and a range-check helper.
// No ports (package).
package booking_pkg;

    localparam int COUNT_W   = 4;
    localparam int FARE_W    = 10;
    localparam int RETRY_W   = 3;
    localparam int MAX_SEATS = 9;
    localparam int MAX_FARE  = 900;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CONFIRM  = 3'd1;
    localparam logic [2:0] ST_ROLLBACK = 3'd2;
    localparam logic [2:0] ST_VERIFY   = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        CONFIRM  = ST_CONFIRM,
        ROLLBACK = ST_ROLLBACK,
        VERIFY   = ST_VERIFY,
        LOCKOUT  = ST_LOCKOUT
    } rec_state_e;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [FARE_W-1:0]  fare;
    } checkpoint_t;

    // True when a booking snapshot lies inside the legal operating range.
    function automatic logic in_limits(input logic [COUNT_W-1:0] count,
                                       input logic [FARE_W-1:0]  fare);
        return (int'(count) <= MAX_SEATS) && (int'(fare) <= MAX_FARE);
    endfunction

endpackage

// File: rtl/recovery_checkpoint_reg.sv
// Checkpoint register for the last known-good booking state.
// Loads count_in/fare_in on capture_en and holds them otherwise.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears to 0/0)
//   capture_en     load enable
//   count_in       live booked_count
//   fare_in        live fare
//   count_out      checkpointed booked_count
//   fare_out       checkpointed fare
module recovery_checkpoint_reg
    import booking_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture_en,
    input  logic [COUNT_W-1:0] count_in,
    input  logic [FARE_W-1:0]  fare_in,
    output logic [COUNT_W-1:0] count_out,
    output logic [FARE_W-1:0]  fare_out
);

    checkpoint_t ckpt_q;
    checkpoint_t ckpt_d;

    always_comb begin
        ckpt_d = ckpt_q;
        if (capture_en) begin
            ckpt_d.count = count_in;
            ckpt_d.fare  = fare_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckpt_q <= '0;
        end else begin
            ckpt_q <= ckpt_d;
        end
    end

    assign count_out = ckpt_q.count;
    assign fare_out  = ckpt_q.fare;

endmodule

// File: rtl/fault_recovery_controller.sv
// Fault recovery controller: consumer end of the booking fault path.
// Checkpoints the last known-good booked_count/fare, confirms a persistent
// fault, holds bookings, replays the checkpoint over a valid/ready restore
// handshake, verifies the heal and escalates to a sticky lockout after
// MAX_RETRIES failed restores.
// Optional build macro FAULT_RECOVERY_STATS_EN adds heal_events/lockout_events
// saturating counters (not cleared by clear_lockout).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   fault_flag      registered fault indication
//   booked_count    live booked seat count
//   fare            live fare value
//   commit_valid    booking committed this cycle
//   restore_ready   booking datapath accepts restore data
//   clear_lockout   operator release of LOCKOUT
//   restore_valid   restore data valid
//   restore_count   checkpointed booked_count
//   restore_fare    checkpointed fare
//   booking_hold    block new bookings (all states except IDLE)
//   heal_done       one-cycle pulse on successful heal
//   lockout         sticky unrecoverable-fault indication
//   retry_cnt       restore attempts in the current episode
//   heal_events     (stats build) successful heals, saturating at 255
//   lockout_events  (stats build) lockout entries, saturating at 15
module fault_recovery_controller
    import booking_pkg::*;
#(
    parameter int unsigned CONFIRM_CYCLES = 3,
    parameter int unsigned VERIFY_CYCLES  = 4,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fault_flag,
    input  logic [COUNT_W-1:0] booked_count,
    input  logic [FARE_W-1:0]  fare,
    input  logic               commit_valid,
    input  logic               restore_ready,
    input  logic               clear_lockout,
    output logic               restore_valid,
    output logic [COUNT_W-1:0] restore_count,
    output logic [FARE_W-1:0]  restore_fare,
    output logic               booking_hold,
    output logic               heal_done,
    output logic               lockout,
`ifdef FAULT_RECOVERY_STATS_EN
    output logic [7:0]         heal_events,
    output logic [3:0]         lockout_events,
`endif
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CONF_W = $clog2(CONFIRM_CYCLES + 1);
    localparam int VCNT_W = (VERIFY_CYCLES > 1) ? $clog2(VERIFY_CYCLES) : 1;

    localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_CYCLES);
    localparam logic [VCNT_W-1:0]  VCNT_LAST  = VCNT_W'(VERIFY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

    rec_state_e         state_q, state_d;
    logic [CONF_W-1:0]  conf_cnt_q, conf_cnt_d;
    logic [VCNT_W-1:0]  vcnt_q, vcnt_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               restore_valid_q, restore_valid_d;
    logic               booking_hold_q, booking_hold_d;
    logic               heal_done_q, heal_done_d;
    logic               lockout_q, lockout_d;
    logic               capture_en;
    logic [CONF_W-1:0]  conf_inc;

    assign conf_inc = conf_cnt_q + CONF_W'(1);

    recovery_checkpoint_reg u_checkpoint (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_en (capture_en),
        .count_in   (booked_count),
        .fare_in    (fare),
        .count_out  (restore_count),
        .fare_out   (restore_fare)
    );

    always_comb begin
        state_d     = state_q;
        conf_cnt_d  = conf_cnt_q;
        vcnt_d      = vcnt_q;
        retry_cnt_d = retry_cnt_q;
        heal_done_d = 1'b0;
        capture_en  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a clean commit is trusted as known-good.
                capture_en = commit_valid && !fault_flag;
                if (fault_flag) begin
                    if (CONFIRM_CYCLES == 1) begin
                        state_d    = ROLLBACK;
                        conf_cnt_d = '0;
                    end else begin
                        state_d    = CONFIRM;
                        conf_cnt_d = CONF_W'(1);
                    end
                end
            end
            CONFIRM: begin
                if (!fault_flag) begin
                    state_d    = IDLE;
                    conf_cnt_d = '0;
                end else if (conf_inc == CONF_LAST) begin
                    state_d    = ROLLBACK;
                    conf_cnt_d = '0;
                end else begin
                    conf_cnt_d = conf_inc;
                end
            end
            ROLLBACK: begin
                if (restore_valid_q && restore_ready) begin
                    state_d     = VERIFY;
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                    vcnt_d      = '0;
                end
            end
            VERIFY: begin
                // Give the datapath VERIFY_CYCLES to settle; judge only at the end.
                if (vcnt_q == VCNT_LAST) begin
                    vcnt_d = '0;
                    if (!fault_flag) begin
                        state_d     = IDLE;
                        heal_done_d = 1'b1;
                        retry_cnt_d = '0;
                    end else if (retry_cnt_q < RETRY_LAST) begin
                        state_d = ROLLBACK;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end else begin
                    vcnt_d = vcnt_q + VCNT_W'(1);
                end
            end
            LOCKOUT: begin
                if (clear_lockout) begin
                    state_d     = IDLE;
                    retry_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                conf_cnt_d  = '0;
                vcnt_d      = '0;
                retry_cnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are flop outputs
    // aligned with the state they describe.
    always_comb begin
        restore_valid_d = (state_d == ROLLBACK);
        booking_hold_d  = (state_d != IDLE);
        lockout_d       = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            conf_cnt_q      <= '0;
            vcnt_q          <= '0;
            retry_cnt_q     <= '0;
            restore_valid_q <= 1'b0;
            booking_hold_q  <= 1'b0;
            heal_done_q     <= 1'b0;
            lockout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            conf_cnt_q      <= conf_cnt_d;
            vcnt_q          <= vcnt_d;
            retry_cnt_q     <= retry_cnt_d;
            restore_valid_q <= restore_valid_d;
            booking_hold_q  <= booking_hold_d;
            heal_done_q     <= heal_done_d;
            lockout_q       <= lockout_d;
        end
    end

    assign restore_valid = restore_valid_q;
    assign booking_hold  = booking_hold_q;
    assign heal_done     = heal_done_q;
    assign lockout       = lockout_q;
    assign retry_cnt     = retry_cnt_q;

`ifdef FAULT_RECOVERY_STATS_EN
    logic [7:0] heal_events_q, heal_events_d;
    logic [3:0] lockout_events_q, lockout_events_d;

    always_comb begin
        heal_events_d    = heal_events_q;
        lockout_events_d = lockout_events_q;
        if (heal_done_d && (heal_events_q != 8'hFF)) begin
            heal_events_d = heal_events_q + 8'd1;
        end
        // Count entries into LOCKOUT, not cycles spent there.
        if ((state_d == LOCKOUT) && (state_q != LOCKOUT) && (lockout_events_q != 4'hF)) begin
            lockout_events_d = lockout_events_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heal_events_q    <= '0;
            lockout_events_q <= '0;
        end else begin
            heal_events_q    <= heal_events_d;
            lockout_events_q <= lockout_events_d;
        end
    end

    assign heal_events    = heal_events_q;
    assign lockout_events = lockout_events_q;
`endif

endmodule

// File: tb/tb_fault_recovery_controller.sv
// Self-checking bench for fault_recovery_controller (default parameters).
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a behavioural model of the recovery episode.
module tb_fault_recovery_controller;

    localparam int CONFIRM_CYCLES = 3;
    localparam int VERIFY_CYCLES  = 4;
    localparam int MAX_RETRIES    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fault_flag;
    logic [3:0] booked_count;
    logic [9:0] fare;
    logic       commit_valid;
    logic       restore_ready;
    logic       clear_lockout;
    logic       restore_valid;
    logic [3:0] restore_count;
    logic [9:0] restore_fare;
    logic       booking_hold;
    logic       heal_done;
    logic       lockout;
    logic [2:0] retry_cnt;
`ifdef FAULT_RECOVERY_STATS_EN
    logic [7:0] heal_events;
    logic [3:0] lockout_events;
`endif

    fault_recovery_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fault_flag     (fault_flag),
        .booked_count   (booked_count),
        .fare           (fare),
        .commit_valid   (commit_valid),
        .restore_ready  (restore_ready),
        .clear_lockout  (clear_lockout),
        .restore_valid  (restore_valid),
        .restore_count  (restore_count),
        .restore_fare   (restore_fare),
        .booking_hold   (booking_hold),
        .heal_done      (heal_done),
        .lockout        (lockout),
`ifdef FAULT_RECOVERY_STATS_EN
        .heal_events    (heal_events),
        .lockout_events (lockout_events),
`endif
        .retry_cnt      (retry_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the episode phase plus plain counters.
    // phase: 0 normal, 1 suspecting, 2 restoring, 3 verifying, 4 locked
    int m_phase, m_streak, m_wait, m_attempts, m_ck_count, m_ck_fare;
    int m_heal, m_heals, m_locks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_streak = 0; m_wait = 0; m_attempts = 0;
        m_ck_count = 0; m_ck_fare = 0; m_heal = 0; m_heals = 0; m_locks = 0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void model_step();
        int nxt;
        nxt = m_phase;
        m_heal = 0;
        case (m_phase)
            0: begin
                if (commit_valid && !fault_flag) begin
                    m_ck_count = int'(booked_count);
                    m_ck_fare  = int'(fare);
                end
                if (fault_flag) begin
                    m_streak = 1;
                    nxt = (m_streak >= CONFIRM_CYCLES) ? 2 : 1;
                end
            end
            1: begin
                if (!fault_flag) begin
                    m_streak = 0;
                    nxt = 0;
                end else begin
                    m_streak++;
                    if (m_streak >= CONFIRM_CYCLES) nxt = 2;
                end
            end
            2: begin
                if (restore_ready) begin
                    m_attempts++;
                    m_wait = VERIFY_CYCLES;
                    nxt = 3;
                end
            end
            3: begin
                m_wait--;
                if (m_wait == 0) begin
                    if (!fault_flag) begin
                        nxt = 0;
                        m_heal = 1;
                        m_attempts = 0;
                        if (m_heals < 255) m_heals++;
                    end else if (m_attempts < MAX_RETRIES) begin
                        nxt = 2;
                    end else begin
                        nxt = 4;
                        if (m_locks < 15) m_locks++;
                    end
                end
            end
            4: begin
                if (clear_lockout) begin
                    nxt = 0;
                    m_attempts = 0;
                end
            end
            default: nxt = 0;
        endcase
        m_phase = nxt;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".restore_valid"}, 32'(restore_valid), 32'(m_phase == 2));
        chk({where, ".booking_hold"},  32'(booking_hold),  32'(m_phase != 0));
        chk({where, ".lockout"},       32'(lockout),       32'(m_phase == 4));
        chk({where, ".heal_done"},     32'(heal_done),     32'(m_heal));
        chk({where, ".retry_cnt"},     32'(retry_cnt),     32'(m_attempts));
        chk({where, ".restore_count"}, 32'(restore_count), 32'(m_ck_count));
        chk({where, ".restore_fare"},  32'(restore_fare),  32'(m_ck_fare));
`ifdef FAULT_RECOVERY_STATS_EN
        chk({where, ".heal_events"},    32'(heal_events),    32'(m_heals));
        chk({where, ".lockout_events"}, 32'(lockout_events), 32'(m_locks));
`endif
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    int  restores;
    bit  seen;

    initial begin
        rst_n = 1'b0; fault_flag = 1'b0; booked_count = '0; fare = '0;
        commit_valid = 1'b0; restore_ready = 1'b0; clear_lockout = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle");

        // Checkpoint capture then confirmed fault
        commit_valid = 1'b1; booked_count = 4'd5; fare = 10'd300;
        cycle("commit");
        commit_valid = 1'b0;
        cycle("idle2");
        chk("ckpt_count", 32'(restore_count), 32'd5);
        chk("ckpt_fare",  32'(restore_fare),  32'd300);
        fault_flag = 1'b1;
        cycle("conf1");
        chk("hold_latency", 32'(booking_hold), 32'd1);
        cycle("conf2");
        chk("valid_early", 32'(restore_valid), 32'd0);
        cycle("conf3");
        chk("valid_latency", 32'(restore_valid), 32'd1);
        chk("restore_count", 32'(restore_count), 32'd5);
        chk("restore_fare",  32'(restore_fare),  32'd300);

        // Handshake back-pressure then heal; commits during VERIFY ignored
        for (int i = 0; i < 5; i++) begin
            cycle("stall");
            chk("stall_valid", 32'(restore_valid), 32'd1);
            chk("stall_count", 32'(restore_count), 32'd5);
        end
        restore_ready = 1'b1;
        cycle("handshake");
        chk("retry_after_hs", 32'(retry_cnt), 32'd1);
        restore_ready = 1'b0; fault_flag = 1'b0;
        commit_valid = 1'b1; booked_count = 4'd7; fare = 10'd500;
        cycle("verify0");
        cycle("verify1");
        commit_valid = 1'b0;
        cycle("verify2");
        chk("verify_no_heal", 32'(heal_done), 32'd0);
        cycle("verify3");
        chk("heal_pulse", 32'(heal_done), 32'd1);
        chk("heal_idle",  32'(booking_hold), 32'd0);
        chk("ckpt_kept_count", 32'(restore_count), 32'd5);
        chk("ckpt_kept_fare",  32'(restore_fare),  32'd300);
        cycle("post_heal");
        chk("heal_one_cycle", 32'(heal_done), 32'd0);

        // Glitch filtered in CONFIRM
        fault_flag = 1'b1;
        cycle("glitch1");
        cycle("glitch2");
        chk("glitch_hold", 32'(booking_hold), 32'd1);
        fault_flag = 1'b0;
        cycle("glitch_end");
        chk("glitch_idle",  32'(booking_hold),  32'd0);
        chk("glitch_valid", 32'(restore_valid), 32'd0);
        chk("glitch_retry", 32'(retry_cnt),     32'd0);

        // Escalation to lockout with fault held
        fault_flag = 1'b1; restore_ready = 1'b1;
        restores = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (restore_valid === 1'b1) restores++;
            cycle("escalate");
            if (lockout === 1'b1) seen = 1'b1;
        end
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL escalate_timeout observed=0 expected=1");
        end
        chk("escalate_restores", 32'(restores), 32'd2);
        chk("lockout_retry", 32'(retry_cnt), 32'd2);
        fault_flag = 1'b0; restore_ready = 1'b0;
        cycle("locked1");
        cycle("locked2");
        chk("lockout_sticky", 32'(lockout), 32'd1);
        clear_lockout = 1'b1;
        cycle("clear");
        clear_lockout = 1'b0;
        chk("clear_lockout", 32'(lockout),   32'd0);
        chk("clear_retry",   32'(retry_cnt), 32'd0);

        // Asynchronous reset during ROLLBACK
        fault_flag = 1'b1;
        cycle("r_conf1");
        cycle("r_conf2");
        cycle("r_conf3");
        chk("pre_reset_valid", 32'(restore_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_valid_drop", 32'(restore_valid), 32'd0);
        check_all("async_reset");
        fault_flag = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_reset");
        chk("reset_ckpt_count", 32'(restore_count), 32'd0);
        chk("reset_ckpt_fare",  32'(restore_fare),  32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 8) fault_flag = ~fault_flag;
            commit_valid  = 1'($urandom_range(0, 1));
            booked_count  = 4'($urandom_range(0, 15));
            fare          = 10'($urandom_range(0, 1023));
            restore_ready = ($urandom_range(0, 99) < 60);
            clear_lockout = ($urandom_range(0, 99) < 5);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
